multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath; replaces one-cycle-per-instruction control with a Moore FSM.
- Steps each instruction through fetch, decode, execute, memory, writeback and branch phases, and handshakes with instruction and data memories that may stall.
- Sits beside the existing combinational control decoder. It gates that decoder's regwrite, memread, memwrite and PC-update effects so each fires exactly once, in the correct phase.
- Also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
- TIMEOUT, 16: max cycles waiting for imem_ready or dmem_ready before trapping. 0 disables the timeout.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- resetl  in  1  asynchronous, active-low reset.
- opcode  in  11  instruction bits [31:21] from IR. Valid from DECODE onward; sampled only in DECODE.
- imem_ready  in  1  instruction memory has instruction data this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- alu_zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- alu_en  out  1  ALU operand and result registers update.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  data access is a write.
- reg_write  out  1  register file write enable.
- mem2reg  out  1  writeback selects memory data.
- pc_write  out  1  PC update; pulses once per retired instruction.
- pc_src  out  1  0 = PC+4, 1 = PC+extended offset.
- state  out  3  current state encoding.
- retired  out  RET_W  retired-instruction count, wraps.
- trap  out  1  sequencer halted.
- trap_cause  out  2  01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.

Behaviour:
- Clock port CLK. Reset resetl is asynchronous, active-low: it clears immediately, with no clock needed.
- Reset state: FETCH. retired=0, wait counter=0, class register=0, zero register=0, trap=0, trap_cause=00. All outputs take their FETCH values.
- Reset mid-instruction abandons the instruction: no pc_write, no retire.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, TRAP=6.
- Outputs are decoded from state plus the registered class. ir_write, pc_write and pc_src also depend on same-cycle ready or the registered zero flag.
- Decode is a casez priority match on opcode, in this order:
  - LDUR ??111000010
  - STUR ??111000000
  - ADDREG ?0?01011???
  - SUBREG ?1?01011???
  - ANDREG ?0001010???
  - ORRREG ?0101010???
  - CBZ ?011010????
  - B ?00101?????
  - ADDIMM ?0?10001???
  - SUBIMM ?1?10001???
  - MOVZ 110100101??
  - LSL 11010011011
  - Class is latched in DECODE.
- FETCH: imem_req=1; ir_write = imem_ready. On imem_ready, go to DECODE. A same-cycle ready costs 1 cycle.
- DECODE: B goes to BRANCH; an unmatched opcode goes to TRAP with cause 01; all others go to EXEC.
- EXEC: alu_en=1; alu_zero is registered.
  - CBZ goes to BRANCH.
  - LDUR and STUR go to MEM.
  - ALU classes (ADD/SUB/AND/ORR reg and imm, MOVZ, LSL) go to WB.
- MEM: dmem_req=1; dmem_we=1 for STUR.
  - On dmem_ready, LDUR goes to WB.
  - On dmem_ready, STUR asserts pc_write=1 (pc_src=0) in that cycle and goes to FETCH.
- WB: reg_write=1; mem2reg=1 for LDUR, else 0; pc_write=1, pc_src=0; then FETCH.
- BRANCH: pc_write=1; pc_src=1 for B, pc_src = registered zero for CBZ; then FETCH.
- Latency with zero-wait memories:
  - B: 3 cycles.
  - ALU, STUR, CBZ: 4 cycles.
  - LDUR: 5 cycles.
- retired increments on every pc_write cycle and wraps from 2^RET_W-1 to 0.
- Wait counter:
  - Clears on entering FETCH or MEM.
  - Increments each FETCH or MEM cycle without ready.
  - When it reaches TIMEOUT with ready still low: go to TRAP, cause 10 (FETCH) or 11 (MEM), with no pc_write.
  - A ready arriving in the same cycle the count is reached wins; no trap.
- TRAP: trap=1, all enables 0, no exit except reset.
- Outside their own states, reg_write, dmem_req, pc_write and ir_write are always 0.

Test Plan:
- ADDREG 10001011000, ready held high: states 0,1,2,4 then 0. reg_write and pc_write high only in cycle 4, pc_src=0; retired 0 to 1.
- LDUR 11111000010, dmem_ready low 3 cycles: MEM lasts 4 cycles with dmem_req=1, dmem_we=0. Then WB with mem2reg=1 and reg_write=1; total 8 cycles.
- CBZ 10110100000: with alu_zero=1 in EXEC, BRANCH gives pc_src=1. Repeat with alu_zero=0: pc_src=0. pc_write=1 in both cases.
- STUR 11111000000 then B 00010100000: STUR pc_write in MEM, with reg_write never asserted. B runs DECODE to BRANCH with pc_src=1; retired=2.
- Opcode 00000000000: TRAP, trap_cause=01, no further imem_req. Assert resetl=0 mid-TRAP: state=0 and trap=0 immediately, without a clock edge.
- TIMEOUT=16, imem_ready held low: TRAP after 16 FETCH cycles, cause 10. Same setup with ready arriving on cycle 16: no trap.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle Moore control sequencer for the LEGv8 datapath
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM, WB and BRANCH.
// It gates the combinational decoder's side effects so that each one fires
// exactly once, in the right phase. It also counts retired instructions and
// halts in TRAP on an illegal opcode or on a memory that never answers.
//
// Parameters
//   TIMEOUT    cycles to wait for imem_ready/dmem_ready before trapping (0 = never)
//   RET_W      width of the retired-instruction counter
//
// Ports
//   CLK          in   clock, rising edge
//   resetl       in   asynchronous active-low reset
//   opcode       in   IR[31:21], sampled in DECODE only
//   imem_ready   in   instruction memory has data this cycle
//   dmem_ready   in   data memory completes the access this cycle
//   alu_zero     in   ALU zero flag, registered in EXEC
//   imem_req     out  instruction fetch request
//   ir_write     out  load IR
//   alu_en       out  ALU operand/result registers update
//   dmem_req     out  data memory request
//   dmem_we      out  data access is a write
//   reg_write    out  register file write enable
//   mem2reg      out  writeback selects memory data
//   pc_write     out  PC update, one pulse per retired instruction
//   pc_src       out  0 = PC+4, 1 = PC+extended offset
//   state        out  current state encoding
//   retired      out  retired-instruction count (wraps)
//   trap         out  sequencer halted
//   trap_cause   out  01 illegal opcode, 10 imem timeout, 11 dmem timeout

module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic [10:0]      opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_zero,
    output logic             imem_req,
    output logic             ir_write,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             pc_write,
    output logic             pc_src,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_NONE   = 4'd0,
        C_LDUR   = 4'd1,
        C_STUR   = 4'd2,
        C_ADDREG = 4'd3,
        C_SUBREG = 4'd4,
        C_ANDREG = 4'd5,
        C_ORRREG = 4'd6,
        C_CBZ    = 4'd7,
        C_B      = 4'd8,
        C_ADDIMM = 4'd9,
        C_SUBIMM = 4'd10,
        C_MOVZ   = 4'd11,
        C_LSL    = 4'd12
    } class_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    // The wait counter only has to reach TIMEOUT-1. The trap decision is made
    // on the cycle that would bring it to TIMEOUT.
    localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TO_EN     = (TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q,      state_d;
    class_e              class_q,      class_d;
    logic                zero_q,       zero_d;
    logic [WAIT_W-1:0]   wait_q,       wait_d;
    logic [RET_W-1:0]    retired_q,    retired_d;
    logic [1:0]          cause_q,      cause_d;

    // The opcode fields overlap, so the item order matters. The first match wins.
    function automatic class_e decode_class(input logic [10:0] op);
        class_e c;
        casez (op)
            11'b??111000010: c = C_LDUR;
            11'b??111000000: c = C_STUR;
            11'b?0?01011???: c = C_ADDREG;
            11'b?1?01011???: c = C_SUBREG;
            11'b?0001010???: c = C_ANDREG;
            11'b?0101010???: c = C_ORRREG;
            11'b?011010????: c = C_CBZ;
            11'b?00101?????: c = C_B;
            11'b?0?10001???: c = C_ADDIMM;
            11'b?1?10001???: c = C_SUBIMM;
            11'b110100101??: c = C_MOVZ;
            11'b11010011011: c = C_LSL;
            default:         c = C_NONE;
        endcase
        return c;
    endfunction

    class_e dec_class;
    assign dec_class = decode_class(opcode);

    // State register and all sequencer-owned state.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            zero_q    <= 1'b0;
            wait_q    <= '0;
            retired_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            zero_q    <= zero_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    // Next state, Moore outputs, and bookkeeping.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        zero_d    = zero_q;
        cause_d   = cause_q;

        imem_req  = 1'b0;
        ir_write  = 1'b0;
        alu_en    = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        mem2reg   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (TO_EN && (wait_q == WAIT_LAST)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end
            end

            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == C_NONE) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_class == C_B) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_en = 1'b1;
                zero_d = alu_zero;
                if (class_q == C_CBZ) begin
                    state_d = S_BRANCH;
                end else if ((class_q == C_LDUR) || (class_q == C_STUR)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == C_STUR);
                if (dmem_ready) begin
                    // A store has nothing left to write back, so it retires here.
                    if (class_q == C_STUR) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (TO_EN && (wait_q == WAIT_LAST)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = (class_q == C_LDUR);
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                pc_write = 1'b1;
                pc_src   = (class_q == C_B) ? 1'b1 : zero_q;
                state_d  = S_FETCH;
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // The wait counter restarts whenever a waiting state is freshly entered.
    // It counts only the cycles that state spends without ready.
    always_comb begin
        wait_d = wait_q;
        if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
            wait_d = '0;
        end else if (((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (pc_write) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    assign state      = state_q;
    assign retired    = retired_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

    localparam int RET_W = 32;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    // Expected-flag bits: {cause[1:0], trap, imem_req, ir_write, alu_en,
    //                      dmem_req, dmem_we, reg_write, mem2reg, pc_write, pc_src, 0}
    localparam logic [12:0] F_C_ILL  = 13'h0800;
    localparam logic [12:0] F_C_IMEM = 13'h1000;
    localparam logic [12:0] F_C_DMEM = 13'h1800;
    localparam logic [12:0] F_TRAP   = 13'h0400;
    localparam logic [12:0] F_IMEM   = 13'h0200;
    localparam logic [12:0] F_IRW    = 13'h0100;
    localparam logic [12:0] F_ALU    = 13'h0080;
    localparam logic [12:0] F_DREQ   = 13'h0040;
    localparam logic [12:0] F_DWE    = 13'h0020;
    localparam logic [12:0] F_REGW   = 13'h0010;
    localparam logic [12:0] F_M2R    = 13'h0008;
    localparam logic [12:0] F_PCW    = 13'h0004;
    localparam logic [12:0] F_PCSRC  = 13'h0002;

    logic             CLK = 1'b0;
    logic             resetl;
    logic [10:0]      opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             alu_zero;
    logic             imem_req;
    logic             ir_write;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_write;
    logic             mem2reg;
    logic             pc_write;
    logic             pc_src;
    logic [2:0]       state;
    logic [RET_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;

    multicycle_sequencer #(.TIMEOUT(16), .RET_W(RET_W)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .alu_zero   (alu_zero),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .alu_en     (alu_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .state      (state),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    always #5 CLK = ~CLK;

    logic [47:0] exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [47:0] act_v;
    logic [47:0] exp_v;
    string       cur_tag;

    assign act_v = {state, trap_cause, trap, imem_req, ir_write, alu_en, dmem_req,
                    dmem_we, reg_write, mem2reg, pc_write, pc_src, 1'b0, retired};

    // Monitor: every cycle the DUT presents a full output word; pop and compare.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_v   = exp_q.pop_front();
            cur_tag = tag_q.pop_front();
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got state=%0d flags=%h retired=%0d, expected state=%0d flags=%h retired=%0d",
                         cur_tag, act_v[47:45], act_v[44:32], act_v[31:0],
                         exp_v[47:45], exp_v[44:32], exp_v[31:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input string tag, input logic rl, input logic [10:0] op,
                       input logic ir, input logic dr, input logic z,
                       input logic [2:0] st, input logic [12:0] fl, input logic [31:0] ret);
        resetl     = rl;
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        alu_zero   = z;
        exp_q.push_back({st, fl, ret});
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        resetl = 1'b0; opcode = OP_ADD; imem_ready = 1'b1; dmem_ready = 1'b1; alu_zero = 1'b0;
        @(posedge CLK);
        #1;
        cyc("reset_state", 0, OP_ADD, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 0);

        // ADDREG, all ready high: 0,1,2,4
        cyc("add_fetch",  1, OP_ADD, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 0);
        cyc("add_decode", 1, OP_ADD, 1, 1, 0, 3'd1, 13'h0, 0);
        cyc("add_exec",   1, OP_ADD, 1, 1, 0, 3'd2, F_ALU, 0);
        cyc("add_wb",     1, OP_ADD, 1, 1, 0, 3'd4, F_REGW | F_PCW, 0);

        // LDUR with three dmem wait cycles: 8 cycles total
        cyc("ldur_fetch",  1, OP_LDUR, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 1);
        cyc("ldur_decode", 1, OP_LDUR, 1, 1, 0, 3'd1, 13'h0, 1);
        cyc("ldur_exec",   1, OP_LDUR, 1, 0, 0, 3'd2, F_ALU, 1);
        for (int i = 0; i < 3; i++)
            cyc("ldur_mem_wait", 1, OP_LDUR, 1, 0, 0, 3'd3, F_DREQ, 1);
        cyc("ldur_mem_done", 1, OP_LDUR, 1, 1, 0, 3'd3, F_DREQ, 1);
        cyc("ldur_wb",       1, OP_LDUR, 1, 1, 0, 3'd4, F_REGW | F_M2R | F_PCW, 1);

        // CBZ taken
        cyc("cbz1_fetch",  1, OP_CBZ, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 2);
        cyc("cbz1_decode", 1, OP_CBZ, 1, 1, 0, 3'd1, 13'h0, 2);
        cyc("cbz1_exec",   1, OP_CBZ, 1, 1, 1, 3'd2, F_ALU, 2);
        cyc("cbz1_branch", 1, OP_CBZ, 1, 1, 0, 3'd5, F_PCW | F_PCSRC, 2);
        // CBZ not taken
        cyc("cbz0_fetch",  1, OP_CBZ, 1, 1, 1, 3'd0, F_IMEM | F_IRW, 3);
        cyc("cbz0_decode", 1, OP_CBZ, 1, 1, 1, 3'd1, 13'h0, 3);
        cyc("cbz0_exec",   1, OP_CBZ, 1, 1, 0, 3'd2, F_ALU, 3);
        cyc("cbz0_branch", 1, OP_CBZ, 1, 1, 1, 3'd5, F_PCW, 3);

        // STUR retires in MEM, then B
        cyc("stur_fetch",  1, OP_STUR, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 4);
        cyc("stur_decode", 1, OP_STUR, 1, 1, 0, 3'd1, 13'h0, 4);
        cyc("stur_exec",   1, OP_STUR, 1, 1, 0, 3'd2, F_ALU, 4);
        cyc("stur_mem",    1, OP_STUR, 1, 1, 0, 3'd3, F_DREQ | F_DWE | F_PCW, 4);
        cyc("b_fetch",     1, OP_B,    1, 1, 0, 3'd0, F_IMEM | F_IRW, 5);
        cyc("b_decode",    1, OP_B,    1, 1, 0, 3'd1, 13'h0, 5);
        cyc("b_branch",    1, OP_B,    1, 1, 0, 3'd5, F_PCW | F_PCSRC, 5);

        // Illegal opcode traps; imem_ready high but no further fetch
        cyc("ill_fetch",  1, OP_ILL, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 6);
        cyc("ill_decode", 1, OP_ILL, 1, 1, 0, 3'd1, 13'h0, 6);
        for (int i = 0; i < 3; i++)
            cyc("ill_trap", 1, OP_ILL, 1, 1, 0, 3'd6, F_TRAP | F_C_ILL, 6);
        // Reset dropped mid-cycle; checked before any further rising edge
        cyc("async_reset", 0, OP_ILL, 1, 1, 0, 3'd0, F_IMEM | F_IRW, 0);
        cyc("reset_hold",  0, OP_ILL, 0, 0, 0, 3'd0, F_IMEM, 0);

        // imem never ready: trap after 16 FETCH cycles
        for (int i = 0; i < 16; i++)
            cyc("imem_wait", 1, OP_ADD, 0, 0, 0, 3'd0, F_IMEM, 0);
        cyc("imem_timeout", 1, OP_ADD, 0, 0, 0, 3'd6, F_TRAP | F_C_IMEM, 0);
        cyc("imem_trap_hold", 1, OP_ADD, 1, 1, 0, 3'd6, F_TRAP | F_C_IMEM, 0);
        cyc("reset2", 0, OP_ADD, 0, 0, 0, 3'd0, F_IMEM, 0);

        // Ready on the 16th FETCH cycle wins over the timeout
        for (int i = 0; i < 15; i++)
            cyc("imem_wait2", 1, OP_ADD, 0, 0, 0, 3'd0, F_IMEM, 0);
        cyc("imem_ready16", 1, OP_ADD, 1, 0, 0, 3'd0, F_IMEM | F_IRW, 0);
        cyc("late_decode",  1, OP_ADD, 1, 0, 0, 3'd1, 13'h0, 0);
        cyc("late_exec",    1, OP_ADD, 1, 0, 0, 3'd2, F_ALU, 0);
        cyc("late_wb",      1, OP_ADD, 1, 0, 0, 3'd4, F_REGW | F_PCW, 0);

        // STUR whose data memory never answers
        cyc("dto_fetch",  1, OP_STUR, 1, 0, 0, 3'd0, F_IMEM | F_IRW, 1);
        cyc("dto_decode", 1, OP_STUR, 1, 0, 0, 3'd1, 13'h0, 1);
        cyc("dto_exec",   1, OP_STUR, 1, 0, 0, 3'd2, F_ALU, 1);
        for (int i = 0; i < 16; i++)
            cyc("dmem_wait", 1, OP_STUR, 1, 0, 0, 3'd3, F_DREQ | F_DWE, 1);
        cyc("dmem_timeout", 1, OP_STUR, 1, 1, 0, 3'd6, F_TRAP | F_C_DMEM, 1);

        repeat (2) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queue depth %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
